// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_pkg
// Description : Shared definitions for the RV32IM front-end control-flow
//               logic: datapath width, conditional-branch funct3 encodings,
//               2-bit bimodal counter states, redirect FSM state type and the
//               saturating counter update helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

    localparam int XLEN = 32;

    // Conditional-branch funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Bimodal 2-bit counter states; bit 1 is the taken prediction
    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } bru_state_e;

    // Saturating increment on taken, saturating decrement on not-taken
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken) begin
            if (cnt != CNT_ST) res = cnt + 2'd1;
        end else begin
            if (cnt != CNT_SNT) res = cnt - 2'd1;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bht_2bit.sv
`default_nettype none
// ============================================================================
// Module      : bht_2bit
// Description : Branch history table of 2**IDX_W bimodal 2-bit counters.
//               Combinational read port, one saturating-update write port.
//               A read of the entry being written returns the pre-update
//               value (no bypass). All entries reset to weakly not-taken.
// Ports       : clk, rst_n       - clock, async active-low reset
//               rd_idx / rd_cnt  - read index / counter value
//               wr_en, wr_idx    - update enable / index
//               wr_taken         - resolved direction for the update
// Revision    : 1.0 - initial release
// ============================================================================
module bht_2bit
    import rv32_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int ENTRIES = 2 ** IDX_W;

    logic [1:0] table_w [ENTRIES];

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic [1:0] cnt_d;
            logic [1:0] cnt_q;

            always_comb begin
                cnt_d = cnt_q;
                if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    cnt_d = sat_update(cnt_q, wr_taken);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) cnt_q <= CNT_WNT;
                else        cnt_q <= cnt_d;
            end

            assign table_w[gi] = cnt_q;
        end
    endgenerate

    assign rd_cnt = table_w[rd_idx];

endmodule
`default_nettype wire

// File: rtl/branch_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_redirect_unit
// Description : Front-end control-flow sequencer. Predicts conditional
//               branches in ID from a bimodal BHT, resolves them in EX and
//               sequences PC redirects and pipeline flushes.
// Ports       : clk, rst_n, stall                  - clock/reset/hazard stall
//               id_*            (in)  ID instruction info
//               id_pred_taken   (out) ID branch prediction
//               ex_*            (in)  EX instruction info and resolution
//               pc_sel/pc_target(out) PC mux control and redirect address
//               flush_if_id/flush_id_ex (out) pipeline squash
//               branch_count/mispred_count (out) saturating perf counters
// Revision    : 1.0 - initial release
// ============================================================================
module branch_redirect_unit
    import rv32_pkg::*;
#(
    parameter int XLEN_P    = XLEN,
    parameter int BHT_IDX_W = 6,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              id_valid,
    input  logic              id_branch,
    input  logic [XLEN_P-1:0] id_pc,
    input  logic [XLEN_P-1:0] id_target,
    output logic              id_pred_taken,
    input  logic              ex_valid,
    input  logic              ex_branch,
    input  logic              ex_jump,
    input  logic [XLEN_P-1:0] ex_pc,
    input  logic [XLEN_P-1:0] ex_target,
    input  logic              ex_taken,
    input  logic              ex_pred_taken,
    output logic              pc_sel,
    output logic [XLEN_P-1:0] pc_target,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  mispred_count
);

    bru_state_e        state_d, state_q;
    logic [XLEN_P-1:0] target_d, target_q;
    logic [CNT_W-1:0]  branch_count_d, branch_count_q;
    logic [CNT_W-1:0]  mispred_count_d, mispred_count_q;

    logic [1:0]        bht_rd_cnt;
    logic              ex_fire;
    logic              ex_mispred;
    logic              bht_wr_en;
    logic [XLEN_P-1:0] ex_fix_target;

    logic unused_id_pc_bits;
    assign unused_id_pc_bits = ^{id_pc[XLEN_P-1:BHT_IDX_W+2], id_pc[1:0]};

    bht_2bit #(
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (id_pc[BHT_IDX_W+1:2]),
        .rd_cnt   (bht_rd_cnt),
        .wr_en    (bht_wr_en),
        .wr_idx   (ex_pc[BHT_IDX_W+1:2]),
        .wr_taken (ex_taken)
    );

    // EX only resolves once per instruction: a stalled EX slot is seen again
    // next cycle, so resolution waits for the cycle it actually advances.
    // Everything in EX while redirecting is wrong-path and ignored.
    always_comb begin
        ex_fire       = (state_q == ST_RUN) && ex_valid && !stall;
        ex_mispred    = ex_fire && ((ex_branch && (ex_taken != ex_pred_taken)) || ex_jump);
        bht_wr_en     = ex_fire && ex_branch;
        ex_fix_target = (ex_taken || ex_jump) ? ex_target : (ex_pc + XLEN_P'(4));
    end

    always_comb begin
        state_d         = state_q;
        target_d        = target_q;
        branch_count_d  = branch_count_q;
        mispred_count_d = mispred_count_q;
        id_pred_taken   = 1'b0;
        pc_sel          = 1'b0;
        pc_target       = '0;
        flush_if_id     = 1'b0;
        flush_id_ex     = 1'b0;

        case (state_q)
            ST_RUN: begin
                id_pred_taken = id_valid && id_branch && bht_rd_cnt[1];
                // A same-cycle EX mispredict does not suppress this: the ID
                // redirect drives now and the older EX redirect overrides it
                // on the following cycle.
                if (id_pred_taken && !stall) begin
                    pc_sel      = 1'b1;
                    pc_target   = id_target;
                    flush_if_id = 1'b1;
                end
                if (ex_fire && ex_branch && (branch_count_q != '1)) begin
                    branch_count_d = branch_count_q + CNT_W'(1);
                end
                if (ex_mispred) begin
                    state_d  = ST_REDIRECT;
                    target_d = ex_fix_target;
                    if (mispred_count_q != '1) begin
                        mispred_count_d = mispred_count_q + CNT_W'(1);
                    end
                end
            end
            ST_REDIRECT: begin
                pc_sel      = 1'b1;
                pc_target   = target_q;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                if (!stall) state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_RUN;
            target_q        <= '0;
            branch_count_q  <= '0;
            mispred_count_q <= '0;
        end else begin
            state_q         <= state_d;
            target_q        <= target_d;
            branch_count_q  <= branch_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign branch_count  = branch_count_q;
    assign mispred_count = mispred_count_q;

endmodule
`default_nettype wire
